// File: rtl/sys_seg7_scan.sv
// Hex scan driver for a common-anode seven-segment bank.
// Snapshots the value once per frame so digits never tear mid-scan.
module sys_seg7_scan #(
    parameter int DATA_W     = 27,
    parameter int NUM_DIGITS = 7,
    parameter int DIV        = 50000
) (
    input  logic                  SYS_clk,
    input  logic                  SYS_reset,
    input  logic [DATA_W-1:0]     SEG_value,
    input  logic                  SEG_hold,
    input  logic                  SEG_blank_lz,
    output logic [NUM_DIGITS-1:0] SEG_an,
    output logic [6:0]            SEG_seg,
    output logic                  SEG_dp,
    output logic                  SEG_frame
);

    localparam int CNT_W = $clog2(DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]  div_cnt;
    logic [DIG_W-1:0]  digit;
    logic [DATA_W-1:0] snapshot;

    logic              tick;
    logic              wrap;
    logic [DIG_W-1:0]  nxt_digit;
    logic [DATA_W-1:0] nxt_snap;
    logic [31:0]       upper;
    logic [3:0]        nib;
    logic              blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Outputs are registered from next-state, so each edge shows the new slot.
    always_comb begin
        tick      = (div_cnt == LAST_CNT);
        wrap      = tick && (digit == LAST_DIG);
        nxt_digit = digit;
        if (tick) begin
            nxt_digit = wrap ? '0 : digit + DIG_W'(1);
        end
        nxt_snap = (wrap && !SEG_hold) ? SEG_value : snapshot;
        upper    = 32'(nxt_snap) >> (4 * nxt_digit);
        nib      = upper[3:0];
        blank    = SEG_blank_lz && (nxt_digit != '0) && (upper == '0);
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            div_cnt   <= '0;
            digit     <= '0;
            snapshot  <= '0;
            SEG_an    <= '1;
            SEG_seg   <= 7'h7F;
            SEG_dp    <= 1'b1;
            SEG_frame <= 1'b0;
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + CNT_W'(1);
            digit     <= nxt_digit;
            snapshot  <= nxt_snap;
            SEG_frame <= wrap;
            SEG_dp    <= !((nxt_digit == '0) && SEG_hold);
            if (blank) begin
                SEG_an  <= '1;
                SEG_seg <= 7'h7F;
            end else begin
                SEG_an  <= ~(NUM_DIGITS'(1) << nxt_digit);
                SEG_seg <= hex7(nib);
            end
        end
    end

endmodule

// File: tb/tb_sys_seg7_scan.sv
// Bench for sys_seg7_scan: per-cycle model compare plus directed
// literal checks of scan order, snapshot, hold, blanking and reset.
module tb_sys_seg7_scan;

    localparam int DIV = 4;
    localparam int ND  = 7;
    localparam int FP  = DIV * ND;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [26:0] value = '0;
    logic        hold = 1'b0;
    logic        blz = 1'b0;
    logic [6:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int checks = 0;
    int failures = 0;

    sys_seg7_scan #(.DATA_W(27), .NUM_DIGITS(ND), .DIV(DIV)) dut (
        .SYS_clk(clk),
        .SYS_reset(rst_n),
        .SEG_value(value),
        .SEG_hold(hold),
        .SEG_blank_lz(blz),
        .SEG_an(an),
        .SEG_seg(seg),
        .SEG_dp(dp),
        .SEG_frame(frame)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Model: edge count since reset release decides slot and frame wrap.
    int          n;
    int          md;
    logic [26:0] msnap;
    logic [31:0] mup;
    logic        mblank;
    logic [6:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_frame;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            msnap = '0;
            e_an = 7'h7F;
            e_seg = 7'h7F;
            e_dp = 1'b1;
            e_frame = 1'b0;
        end else begin
            n = n + 1;
            if (n % FP == 0 && !hold) msnap = value;
            md = (n / DIV) % ND;
            mup = {5'b0, msnap} >> (4 * md);
            mblank = blz && md != 0 && mup == 0;
            e_an = mblank ? 7'h7F : 7'(~(32'd1 << md));
            e_seg = mblank ? 7'h7F : hex_tab[mup[3:0]];
            e_dp = !(md == 0 && hold);
            e_frame = (n % FP == 0);
        end
    end

    always @(negedge clk) begin
        checks = checks + 1;
        if ({an, seg, dp, frame} !== {e_an, e_seg, e_dp, e_frame}) begin
            failures = failures + 1;
            $display("FAIL model t=%0t act an=%h seg=%h dp=%b fr=%b exp an=%h seg=%h dp=%b fr=%b",
                     $time, an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic wait_frame();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame && k < 200);
        chk("frame_timeout", int'(frame), 1);
    endtask

    // s packs {d6,...,d0}; a 7F entry means that slot is blanked.
    task automatic show_frame(input logic [48:0] s, input logic h);
        logic [6:0] e;
        for (int d = 0; d < ND; d++) begin
            if (d > 0) repeat (DIV) @(negedge clk);
            e = s[7*d +: 7];
            chk($sformatf("seg_d%0d", d), int'(seg), int'(e));
            chk($sformatf("an_d%0d", d), int'(an),
                (e == 7'h7F) ? 'h7F : int'(7'(~(7'd1 << d))));
            if (d < 2) chk($sformatf("dp_d%0d", d), int'(dp), (d == 0 && h) ? 0 : 1);
        end
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk("rst_an", int'(an), 'h7F);
        chk("rst_seg", int'(seg), 'h7F);
        chk("rst_dp", int'(dp), 1);
        chk("rst_frame", int'(frame), 0);

        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("first_an", int'(an), 'h7E);
        chk("first_seg", int'(seg), 'h40);
        cnt = 1;
        while (!frame && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("first_frame_cyc", cnt, 28);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame && cnt < 100);
        chk("frame_period", cnt, 28);

        repeat (10) @(negedge clk);
        value = 27'h7654321;
        repeat (6) @(negedge clk);
        chk("midframe_seg", int'(seg), 'h40);
        wait_frame();
        show_frame({7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, 1'b0);

        value = 27'h7FFFFFF;
        wait_frame();
        show_frame({7'h78, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}, 1'b0);

        value = 27'h00000AB;
        wait_frame();
        hold = 1'b1;
        value = 27'h1234567;
        repeat (3) begin
            wait_frame();
            show_frame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h03}, 1'b1);
        end
        hold = 1'b0;
        @(negedge clk);
        chk("release_seg", int'(seg), 'h40);
        wait_frame();
        show_frame({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}, 1'b0);

        value = 27'h00000AB;
        wait_frame();
        blz = 1'b1;
        wait_frame();
        show_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h03}, 1'b0);
        value = 27'h0;
        wait_frame();
        show_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);

        blz = 1'b0;
        value = 27'h7654321;
        wait_frame();
        repeat (12) @(negedge clk);
        chk("pre_rst_an", int'(an), 'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", int'(an), 'h7F);
        chk("async_seg", int'(seg), 'h7F);
        chk("async_frame", int'(frame), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("restart_an", int'(an), 'h7E);
        chk("restart_seg", int'(seg), 'h40);
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
